// File: rtl/spread_pipe.sv
// rtl/spread_pipe.sv - three-stage Avellaneda-Stoikov spread: gamma*sigma2*(T-t) + log, clamped to a floor
module spread_pipe #(
    parameter int FP_WORD_SIZE = 64,
    parameter int FRAC_BITS    = 32,
    parameter int NUM_CHANNELS = 4,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_data_valid,
    output logic                    o_ready,
    input  logic [CH_W-1:0]         i_channel,
    input  logic [FP_WORD_SIZE-1:0] i_risk_factor,
    input  logic [FP_WORD_SIZE-1:0] i_volatility,
    input  logic [FP_WORD_SIZE-1:0] i_curr_time,
    input  logic [FP_WORD_SIZE-1:0] i_horizon,
    input  logic [FP_WORD_SIZE-1:0] i_logarithm,
    input  logic [FP_WORD_SIZE-1:0] i_min_spread,
    output logic                    o_data_valid,
    input  logic                    i_ready,
    output logic [CH_W-1:0]         o_channel,
    output logic [FP_WORD_SIZE-1:0] o_spread,
    output logic [FP_WORD_SIZE-1:0] o_half_spread,
    output logic                    o_saturated
);
    localparam int W  = FP_WORD_SIZE;
    localparam int W2 = 2 * FP_WORD_SIZE;
    localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W2-1:0] EXT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [W2-1:0] EXT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W2-1:0] RND_ADD = {{(W2-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    // Returns {clamped_flag, value}: round-half-up rescale of a full product, then saturate to W bits.
    function automatic logic [W:0] sat_rnd(input logic signed [W2-1:0] prod);
        logic signed [W2-1:0] r;
        r = (prod + RND_ADD) >>> FRAC_BITS;
        if (r > EXT_MAX)
            sat_rnd = {1'b1, MAX_W};
        else if (r < EXT_MIN)
            sat_rnd = {1'b1, MIN_W};
        else
            sat_rnd = {1'b0, r[W-1:0]};
    endfunction

    logic            s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
    logic [W-1:0]    gp_q, gp_d, trem_q, trem_d, s1_log_q, s1_log_d, s1_min_q, s1_min_d;
    logic [CH_W-1:0] s1_ch_q, s1_ch_d;
    logic            s2_valid_q, s2_valid_d, s2_sat_q, s2_sat_d;
    logic [W-1:0]    prod_q, prod_d, s2_log_q, s2_log_d, s2_min_q, s2_min_d;
    logic [CH_W-1:0] s2_ch_q, s2_ch_d;
    logic            out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [W-1:0]    spread_q, spread_d, half_q, half_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;

    logic                 advance;
    logic signed [W2-1:0] mul1, mul2;
    logic [W:0]           r1, r2;
    logic [W-1:0]         diff, sum;
    logic signed [W:0]    sum_ext;
    logic                 sum_sat;

    always_comb begin
        s1_valid_d = s1_valid_q; s1_sat_d = s1_sat_q; gp_d = gp_q; trem_d = trem_q;
        s1_log_d = s1_log_q; s1_min_d = s1_min_q; s1_ch_d = s1_ch_q;
        s2_valid_d = s2_valid_q; s2_sat_d = s2_sat_q; prod_d = prod_q;
        s2_log_d = s2_log_q; s2_min_d = s2_min_q; s2_ch_d = s2_ch_q;
        out_valid_d = out_valid_q; out_sat_d = out_sat_q; spread_d = spread_q;
        half_d = half_q; out_ch_d = out_ch_q;
        mul1 = '0; mul2 = '0; r1 = '0; r2 = '0; diff = '0; sum = '0; sum_ext = '0; sum_sat = 1'b0;

        advance = !out_valid_q || i_ready;

        if (advance) begin
            s1_valid_d = i_data_valid;
            if (i_data_valid) begin
                mul1 = $signed({{W{i_risk_factor[W-1]}}, i_risk_factor})
                     * $signed({{W{i_volatility[W-1]}}, i_volatility});
                r1   = sat_rnd(mul1);
                gp_d = r1[W-1:0];
                diff = i_horizon - i_curr_time;
                if (i_curr_time >= i_horizon) begin
                    trem_d   = '0;
                    s1_sat_d = r1[W];
                end else if (diff[W-1]) begin
                    trem_d   = MAX_W;
                    s1_sat_d = 1'b1;
                end else begin
                    trem_d   = diff;
                    s1_sat_d = r1[W];
                end
                s1_log_d = i_logarithm;
                s1_min_d = i_min_spread;
                s1_ch_d  = i_channel;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                // trem is never negative, so it is zero-extended into the signed product
                mul2     = $signed({{W{gp_q[W-1]}}, gp_q}) * $signed({{W{1'b0}}, trem_q});
                r2       = sat_rnd(mul2);
                prod_d   = r2[W-1:0];
                s2_sat_d = s1_sat_q || r2[W];
                s2_log_d = s1_log_q;
                s2_min_d = s1_min_q;
                s2_ch_d  = s1_ch_q;
            end

            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                sum_ext = $signed({s2_log_q[W-1], s2_log_q}) + $signed({prod_q[W-1], prod_q});
                sum_sat = sum_ext[W] != sum_ext[W-1];
                if (sum_sat)
                    sum = sum_ext[W] ? MIN_W : MAX_W;
                else
                    sum = sum_ext[W-1:0];
                spread_d  = ($signed(sum) < $signed(s2_min_q)) ? s2_min_q : sum;
                half_d    = $signed(spread_d) >>> 1;
                out_sat_d = s2_sat_q || sum_sat;
                out_ch_d  = s2_ch_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0; s1_sat_q <= 1'b0; gp_q <= '0; trem_q <= '0;
            s1_log_q <= '0; s1_min_q <= '0; s1_ch_q <= '0;
            s2_valid_q <= 1'b0; s2_sat_q <= 1'b0; prod_q <= '0;
            s2_log_q <= '0; s2_min_q <= '0; s2_ch_q <= '0;
            out_valid_q <= 1'b0; out_sat_q <= 1'b0; spread_q <= '0;
            half_q <= '0; out_ch_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_sat_q <= s1_sat_d; gp_q <= gp_d; trem_q <= trem_d;
            s1_log_q <= s1_log_d; s1_min_q <= s1_min_d; s1_ch_q <= s1_ch_d;
            s2_valid_q <= s2_valid_d; s2_sat_q <= s2_sat_d; prod_q <= prod_d;
            s2_log_q <= s2_log_d; s2_min_q <= s2_min_d; s2_ch_q <= s2_ch_d;
            out_valid_q <= out_valid_d; out_sat_q <= out_sat_d; spread_q <= spread_d;
            half_q <= half_d; out_ch_q <= out_ch_d;
        end
    end

    assign o_ready       = advance;
    assign o_data_valid  = out_valid_q;
    assign o_channel     = out_ch_q;
    assign o_spread      = spread_q;
    assign o_half_spread = half_q;
    assign o_saturated   = out_sat_q;
endmodule

// File: tb/tb_spread_pipe.sv
// tb/tb_spread_pipe.sv - directed and randomized checks of spread_pipe against an arithmetic reference
module tb_spread_pipe;
    localparam int W    = 64;
    localparam int CH_W = 2;
    localparam logic [63:0] ONE = 64'h1_0000_0000;

    logic            i_clk = 1'b0;
    logic            i_reset, i_data_valid, o_ready, o_data_valid, i_ready, o_saturated;
    logic [CH_W-1:0] i_channel, o_channel;
    logic [W-1:0]    i_risk_factor, i_volatility, i_curr_time, i_horizon, i_logarithm, i_min_spread;
    logic [W-1:0]    o_spread, o_half_spread;

    spread_pipe #(.FP_WORD_SIZE(64), .FRAC_BITS(32), .NUM_CHANNELS(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data_valid(i_data_valid), .o_ready(o_ready),
        .i_channel(i_channel), .i_risk_factor(i_risk_factor), .i_volatility(i_volatility),
        .i_curr_time(i_curr_time), .i_horizon(i_horizon), .i_logarithm(i_logarithm),
        .i_min_spread(i_min_spread), .o_data_valid(o_data_valid), .i_ready(i_ready),
        .o_channel(o_channel), .o_spread(o_spread), .o_half_spread(o_half_spread),
        .o_saturated(o_saturated)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0]     spread;
        logic [63:0]     half;
        logic [CH_W-1:0] ch;
        logic            sat;
        int              acc;
        int              stl;
    } exp_t;

    exp_t            sbq[$];
    int              ncmp = 0, nfail = 0, cyc = 0, stalls = 0;
    logic            prev_stall = 1'b0, accepted = 1'b0;
    logic [63:0]     snap_s, snap_h;
    logic [CH_W-1:0] snap_c;
    logic            snap_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] clamp(input logic signed [255:0] x);
        if (x > 256'sh7FFF_FFFF_FFFF_FFFF) return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        if (x < -256'sh8000_0000_0000_0000) return {1'b1, 64'h8000_0000_0000_0000};
        return {1'b0, x[63:0]};
    endfunction

    // Exact-integer evaluation of the spread formula on real values scaled by 2^32.
    function automatic logic [64:0] model(input logic [63:0] g, s, t, th, lg, mn);
        logic signed [255:0] a, b, trem, half;
        logic [64:0]         c;
        logic                sat;
        half = 256'sd2147483648;
        a = $signed(g);
        b = $signed(s);
        c = clamp((a * b + half) >>> 32);
        sat = c[64];
        a = $signed(c[63:0]);
        if (t >= th) trem = '0;
        else begin
            trem = {192'b0, th} - {192'b0, t};
            if (trem > 256'sh7FFF_FFFF_FFFF_FFFF) begin
                trem = 256'sh7FFF_FFFF_FFFF_FFFF;
                sat = 1'b1;
            end
        end
        c = clamp((a * trem + half) >>> 32);
        sat = sat | c[64];
        a = $signed(c[63:0]);
        b = $signed(lg);
        c = clamp(a + b);
        sat = sat | c[64];
        if ($signed(c[63:0]) < $signed(mn)) return {sat, mn};
        return {sat, c[63:0]};
    endfunction

    task automatic tick();
        exp_t        e;
        logic [64:0] m;
        #1;
        chk("o_ready", 64'(o_ready), 64'(!o_data_valid || i_ready));
        if (prev_stall) begin
            chk("stall_valid", 64'(o_data_valid), 64'd1);
            chk("stall_spread", o_spread, snap_s);
            chk("stall_half", o_half_spread, snap_h);
            chk("stall_ch", 64'(o_channel), 64'(snap_c));
            chk("stall_sat", 64'(o_saturated), 64'(snap_sat));
        end
        if (o_data_valid && i_ready) begin
            if (sbq.size() == 0) chk("unexpected_out", 64'(o_data_valid), 64'd0);
            else begin
                e = sbq.pop_front();
                chk("spread", o_spread, e.spread);
                chk("half", o_half_spread, e.half);
                chk("channel", 64'(o_channel), 64'(e.ch));
                chk("saturated", 64'(o_saturated), 64'(e.sat));
                chk("latency", 64'(cyc - e.acc), 64'(3 + stalls - e.stl));
            end
        end
        if (o_data_valid && !i_ready) stalls++;
        accepted = i_data_valid && o_ready;
        if (accepted) begin
            m = model(i_risk_factor, i_volatility, i_curr_time, i_horizon, i_logarithm, i_min_spread);
            e.spread = m[63:0];
            e.half   = $signed(m[63:0]) >>> 1;
            e.ch     = i_channel;
            e.sat    = m[64];
            e.acc    = cyc;
            e.stl    = stalls;
            sbq.push_back(e);
        end
        prev_stall = o_data_valid && !i_ready;
        snap_s = o_spread; snap_h = o_half_spread; snap_c = o_channel; snap_sat = o_saturated;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drive(input logic [63:0] g, s, t, th, lg, mn, input logic [CH_W-1:0] ch, input logic v);
        i_risk_factor = g; i_volatility = s; i_curr_time = t; i_horizon = th;
        i_logarithm = lg; i_min_spread = mn; i_channel = ch; i_data_valid = v;
    endtask

    task automatic single(input string tag, input logic [63:0] g, s, t, th, lg, mn,
                          input logic [CH_W-1:0] ch, input logic [63:0] exp_sp, input logic exp_sat);
        i_ready = 1'b1;
        drive(g, s, t, th, lg, mn, ch, 1'b1);
        tick();
        i_data_valid = 1'b0;
        chk({tag, "_v1"}, 64'(o_data_valid), 64'd0);
        tick();
        chk({tag, "_v2"}, 64'(o_data_valid), 64'd0);
        tick();
        chk({tag, "_v3"}, 64'(o_data_valid), 64'd1);
        chk({tag, "_spread"}, o_spread, exp_sp);
        chk({tag, "_half"}, o_half_spread, 64'($signed(exp_sp) >>> 1));
        chk({tag, "_ch"}, 64'(o_channel), 64'(ch));
        chk({tag, "_sat"}, 64'(o_saturated), 64'(exp_sat));
        tick();
    endtask

    task automatic drain();
        i_data_valid = 1'b0;
        i_ready = 1'b1;
        repeat (5) tick();
        chk("drained", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd_s();
        longint v;
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
        v = longint'($urandom_range(0, 4194304)) - 64'sd2097152;
        return 64'(v <<< 12);
    endfunction

    function automatic logic [63:0] rnd_t();
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
        return 64'(longint'($urandom_range(0, 1048576)) << 12);
    endfunction

    initial begin
        int rel;
        i_reset = 1'b1;
        i_ready = 1'b1;
        drive('0, '0, '0, '0, '0, '0, '0, 1'b0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", 64'(o_data_valid), 64'd0);
        chk("rst_spread", o_spread, 64'd0);
        chk("rst_half", o_half_spread, 64'd0);
        chk("rst_ch", 64'(o_channel), 64'd0);
        chk("rst_sat", 64'(o_saturated), 64'd0);
        i_reset = 1'b0;
        tick();

        single("t1", 64'h8000_0000, 2 * ONE, ONE, 4 * ONE, ONE, 64'd0, 2'd2, 64'h4_0000_0000, 1'b0);
        single("t2a", 64'h8000_0000, 2 * ONE, 5 * ONE, 4 * ONE, ONE, 64'd0, 2'd1, ONE, 1'b0);
        single("t2b", 64'h8000_0000, 2 * ONE, 5 * ONE, 4 * ONE, ONE, 64'h1_8000_0000, 2'd3,
               64'h1_8000_0000, 1'b0);
        single("t3", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, ONE, 4 * ONE, ONE, 64'd0, 2'd0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        single("t6a", ONE, ONE, 64'd0, ONE, -64'sh3_0000_0000, 64'd0, 2'd1, 64'd0, 1'b0);
        single("t6b", 64'd1, 64'h8000_0000, 64'd0, ONE, 64'd0, 64'd0, 2'd2, 64'd1, 1'b0);
        single("trem_clamp", ONE, ONE, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 2'd3,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

        rel = 0;
        for (int c = 0; c < 4; c++) begin
            drive(64'h8000_0000, 2 * ONE, ONE, 4 * ONE, 64'(c) * ONE, 64'd0, 2'(c), 1'b1);
            for (int k = 0; k < 20; k++) begin
                i_ready = !(rel >= 3 && rel <= 5);
                rel++;
                tick();
                if (accepted) break;
            end
        end
        drain();

        for (int c = 0; c < 3; c++) begin
            drive(64'h8000_0000, 2 * ONE, ONE, 4 * ONE, ONE, 64'd0, 2'(c), 1'b1);
            tick();
        end
        i_data_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(o_data_valid), 64'd0);
        chk("midrst_spread", o_spread, 64'd0);
        sbq.delete();
        prev_stall = 1'b0;
        tick();
        i_reset = 1'b0;
        repeat (4) tick();
        single("post_rst", 64'h8000_0000, 2 * ONE, ONE, 4 * ONE, ONE, 64'd0, 2'd1, 64'h4_0000_0000, 1'b0);

        for (int n = 0; n < 400; n++) begin
            drive(rnd_s(), rnd_s(), rnd_t(), rnd_t(), rnd_s(), rnd_s(), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
            i_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
